char_move_ctrl: RTL and testbench
=================================

# char_move_ctrl

Sequential movement controller for the player character, directly downstream of the collision detector. It accepts a move request from input decode and asks the collision detector whether the target tile is free via a request/done handshake. If the tile is free it walks the character one tile in 1-pixel steps per frame tick; on an enemy contact it applies a one-tile knockback. Its position and direction outputs feed both the collision detector and the sprite drawer.

## Interface
Parameters:
- X_INIT, 160: reset x position (pixels)
- Y_INIT, 112: reset y position (pixels)
- TILE, 16: pixels per move, and the step count
- X_MAX, 304: largest legal x (320-wide screen minus tile)
- Y_MAX, 224: largest legal y (240-high screen minus tile)
- CHK_TIMEOUT, 15: cycles to wait for check_done before treating the move as blocked

Ports:
- clock  in  1  system clock (one clock domain)
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- move_req  in  1  level; player wants to move
- move_dir  in  2  requested direction: UP=00, DOWN=01, LEFT=10, RIGHT=11
- check_req  out  1  enable to the collision detector; held high while waiting
- direction_char  out  2  direction under check or in motion
- check_done  in  1  one-cycle pulse; collision flags are valid in this cycle
- map_collision  in  1  target tile is a wall
- enemy_collision  in  1  target overlaps enemy 1
- x_char  out  9  current x
- y_char  out  8  current y
- facing_char  out  2  sprite facing
- moving  out  1  high in MOVE or KNOCK
- hit  out  1  one-cycle pulse on enemy contact

## Operation
States are IDLE, CHECK, MOVE, KNOCK.
- Reset values: state IDLE, x_char=X_INIT, y_char=Y_INIT, facing_char=DOWN, direction_char=DOWN. check_req, moving and hit are 0. Step and timeout counters are 0.
- IDLE: move_req is sampled here only.
  - On move_req=1, facing_char and direction_char take move_dir on the next edge.
  - Target = current position ±TILE on the request axis, computed in 10 bits (x) or 9 bits (y) so underflow is detectable.
  - If target <0 or >X_MAX/Y_MAX: stay in IDLE; only facing changes.
  - Otherwise go to CHECK.
- CHECK: check_req=1.
  - check_done with map_collision=1 → IDLE; position unchanged.
  - check_done with enemy_collision=1 → hit pulses, then KNOCK. Enemy collision takes priority over map collision.
  - check_done with both flags 0 → MOVE.
  - No check_done within CHK_TIMEOUT cycles → IDLE, treated as blocked. If check_done arrives in the timeout cycle, check_done wins.
- MOVE: moving=1.
  - Each frame_tick moves the position 1 pixel toward direction_char and increments the step counter.
  - When the counter reaches TILE, the position is tile-aligned again: clear the counter and go to IDLE.
  - move_req and check_done are ignored in this state.
- KNOCK: direction_char = opposite of facing_char; facing_char is unchanged.
  - If the knockback target is out of bounds → IDLE immediately with no movement.
  - Otherwise move 1 px per frame_tick for TILE ticks without a collision check, then IDLE.
- A frame_tick in the same cycle the FSM enters MOVE or KNOCK is not counted.
- A reset asserted in any state restores all reset values on the next edge, abandoning a partial move.

## Timing
- IDLE with move_req → check_req high on the next cycle (1-cycle latency).
- check_done in cycle N → state and hit update at edge N+1; check_req is low from N+1.
- A full free move takes TILE frame_ticks plus 2 cycles of handshake overhead.
- Position changes only on frame_tick edges in MOVE or KNOCK.
- hit is exactly one cycle wide.
- Outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package zelda_pkg holds:
  - the direction constants UP/DOWN/LEFT/RIGHT
  - SCREEN_W=320 and SCREEN_H=240
  - TILE=16
  - the state encoding constants
- One sub-module is natural: dir_target, which is combinational. It takes x, y and dir and returns x_t, y_t and in_bounds. It is instantiated twice: once for the forward target and once for the knockback target.

## Test plan
- Reset, then move_req RIGHT → check_req high 1 cycle later. check_done with both flags 0 → after 16 frame_ticks x_char=176, y_char=112, moving falls.
- Start at (0,112) with move_req LEFT → check_req never rises, facing_char=LEFT, position stays (0,112).
- move_req UP, then check_done with map_collision=1 → state IDLE, y_char stays 112, no hit.
- move_req DOWN, then check_done with enemy_collision=1 → hit for exactly 1 cycle. After 16 ticks y_char=96 and facing_char stays DOWN.
- move_req RIGHT with no check_done for 15 cycles → check_req drops, position unchanged, and a new request is accepted.
- Reset asserted after 7 frame_ticks of a move → next cycle position=(160,112), moving=0, state IDLE.

Source files
------------

// File: rtl/zelda_pkg.sv
// Shared constants for the player movement path: direction codes, screen size, tile size, FSM states.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package zelda_pkg;

  // Direction codes; opposite pairs differ only in bit 0.
  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int TILE     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MOVE  = 2'd2,
    ST_KNOCK = 2'd3
  } state_t;

  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/char_move_ctrl_dir_target.sv
// dir_target: position one tile away from (x,y) in direction dir, plus an on-screen flag.
// Latency: combinational.
// Backpressure: none.
// Ports: x/y current position, dir direction; x_t/y_t target (valid when in_bounds), in_bounds target is legal.
module dir_target #(
  parameter int TILE  = 16,
  parameter int X_MAX = 304,
  parameter int Y_MAX = 224
) (
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [1:0] dir,
  output logic [8:0] x_t,
  output logic [7:0] y_t,
  output logic       in_bounds
);
  import zelda_pkg::UP;
  import zelda_pkg::DOWN;
  import zelda_pkg::LEFT;

  localparam logic [9:0] TX = 10'(TILE);
  localparam logic [8:0] TY = 9'(TILE);
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [8:0] YM = 9'(Y_MAX);

  // One extra bit on each axis: a subtraction past zero sets the top bit.
  logic [9:0] xw;
  logic [8:0] yw;

  always_comb begin
    xw = {1'b0, x};
    yw = {1'b0, y};
    case (dir)
      UP:      yw = {1'b0, y} - TY;
      DOWN:    yw = {1'b0, y} + TY;
      LEFT:    xw = {1'b0, x} - TX;
      default: xw = {1'b0, x} + TX;
    endcase
  end

  assign in_bounds = !xw[9] && (xw <= XM) && !yw[8] && (yw <= YM);
  assign x_t = xw[8:0];
  assign y_t = yw[7:0];

endmodule

// File: rtl/char_move_ctrl.sv
// Player movement FSM: collision-checked one-tile walk, or one-tile knockback on enemy contact.
// Latency: move_req -> check_req 1 cycle; check_done -> state/hit 1 cycle; a walk spans TILE frame_ticks.
// Backpressure: move_req is only sampled in IDLE; check_req is held until check_done or timeout.
// Ports: clock/reset; frame_tick step strobe; move_req/move_dir request; check_req/direction_char/
//        check_done/map_collision/enemy_collision collision handshake; x_char/y_char/facing_char/moving/hit status.
module char_move_ctrl #(
  parameter int X_INIT      = 160,
  parameter int Y_INIT      = 112,
  parameter int TILE        = 16,
  parameter int X_MAX       = 304,
  parameter int Y_MAX       = 224,
  parameter int CHK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  output logic       check_req,
  output logic [1:0] direction_char,
  input  logic       check_done,
  input  logic       map_collision,
  input  logic       enemy_collision,
  output logic [8:0] x_char,
  output logic [7:0] y_char,
  output logic [1:0] facing_char,
  output logic       moving,
  output logic       hit
);
  import zelda_pkg::UP;
  import zelda_pkg::DOWN;
  import zelda_pkg::LEFT;
  import zelda_pkg::state_t;
  import zelda_pkg::ST_IDLE;
  import zelda_pkg::ST_CHECK;
  import zelda_pkg::ST_MOVE;
  import zelda_pkg::ST_KNOCK;
  import zelda_pkg::opposite_dir;

  localparam int SW = $clog2(TILE + 1);
  localparam int CW = $clog2(CHK_TIMEOUT + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(TILE - 1);
  localparam logic [CW-1:0] CHK_LAST  = CW'(CHK_TIMEOUT - 1);

  state_t        state;
  logic [SW-1:0] step_cnt;
  logic [CW-1:0] chk_cnt;
  logic [8:0]    tgt_x;
  logic [7:0]    tgt_y;
  logic          knock_ok;

  logic [8:0] fwd_x_t;
  logic [7:0] fwd_y_t;
  logic       fwd_ok;
  logic [1:0] knk_dir;
  logic [8:0] knk_x_t;
  logic [7:0] knk_y_t;
  logic       knk_ok;

  assign knk_dir = opposite_dir(facing_char);

  // Forward target for a fresh request, evaluated in IDLE.
  dir_target #(.TILE(TILE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_fwd (
    .x(x_char), .y(y_char), .dir(move_dir),
    .x_t(fwd_x_t), .y_t(fwd_y_t), .in_bounds(fwd_ok)
  );

  // Knockback target, evaluated while CHECK holds the starting position.
  dir_target #(.TILE(TILE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_knk (
    .x(x_char), .y(y_char), .dir(knk_dir),
    .x_t(knk_x_t), .y_t(knk_y_t), .in_bounds(knk_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      x_char         <= 9'(X_INIT);
      y_char         <= 8'(Y_INIT);
      facing_char    <= DOWN;
      direction_char <= DOWN;
      check_req      <= 1'b0;
      moving         <= 1'b0;
      hit            <= 1'b0;
      step_cnt       <= '0;
      chk_cnt        <= '0;
      tgt_x          <= '0;
      tgt_y          <= '0;
      knock_ok       <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (move_req) begin
            facing_char    <= move_dir;
            direction_char <= move_dir;
            if (fwd_ok) begin
              state     <= ST_CHECK;
              check_req <= 1'b1;
              chk_cnt   <= '0;
              tgt_x     <= fwd_x_t;
              tgt_y     <= fwd_y_t;
            end
          end
        end

        ST_CHECK: begin
          if (check_done) begin
            check_req <= 1'b0;
            step_cnt  <= '0;
            if (enemy_collision) begin
              hit            <= 1'b1;
              moving         <= 1'b1;
              state          <= ST_KNOCK;
              direction_char <= knk_dir;
              tgt_x          <= knk_x_t;
              tgt_y          <= knk_y_t;
              knock_ok       <= knk_ok;
            end else if (map_collision) begin
              state <= ST_IDLE;
            end else begin
              moving <= 1'b1;
              state  <= ST_MOVE;
            end
          end else if (chk_cnt == CHK_LAST) begin
            check_req <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            chk_cnt <= chk_cnt + 1'b1;
          end
        end

        default: begin
          // MOVE and KNOCK share the stepping logic; a knockback into a wall
          // of the screen is abandoned before any step is taken.
          if (state == ST_KNOCK && !knock_ok) begin
            moving <= 1'b0;
            state  <= ST_IDLE;
          end else if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              // Final step lands exactly on the latched tile-aligned target.
              x_char   <= tgt_x;
              y_char   <= tgt_y;
              step_cnt <= '0;
              moving   <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
              case (direction_char)
                UP:      y_char <= y_char - 8'd1;
                DOWN:    y_char <= y_char + 8'd1;
                LEFT:    x_char <= x_char - 9'd1;
                default: x_char <= x_char + 9'd1;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_move_ctrl.sv
module tb_char_move_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       move_req = 1'b0;
  logic [1:0] move_dir = 2'b00;
  logic       check_done = 1'b0;
  logic       map_collision = 1'b0;
  logic       enemy_collision = 1'b0;
  logic       check_req;
  logic [1:0] direction_char;
  logic [8:0] x_char;
  logic [7:0] y_char;
  logic [1:0] facing_char;
  logic       moving;
  logic       hit;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  char_move_ctrl dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .move_req(move_req), .move_dir(move_dir),
    .check_req(check_req), .direction_char(direction_char),
    .check_done(check_done), .map_collision(map_collision),
    .enemy_collision(enemy_collision),
    .x_char(x_char), .y_char(y_char), .facing_char(facing_char),
    .moving(moving), .hit(hit)
  );

  always #5 clock = ~clock;

  // Behavioural model: the character is resting, asking the collision
  // detector, or sliding with a number of pixels still to travel.
  localparam int REST = 0, ASK = 1, SLIDE = 2;
  int dx [4] = '{0, 0, -1, 1};
  int dy [4] = '{-1, 1, 0, 0};
  int opp[4] = '{1, 0, 3, 2};
  int m_x = 160, m_y = 112, m_face = 1, m_dir = 1;
  int phase = REST, remaining = 0, waited = 0;
  int m_hit = 0;

  function automatic bit on_screen(input int px, input int py);
    return (px >= 0) && (px <= 304) && (py >= 0) && (py <= 224);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_x = 160; m_y = 112; m_face = 1; m_dir = 1;
      phase = REST; remaining = 0; waited = 0; m_hit = 0;
    end else begin
      m_hit = 0;
      if (phase == REST) begin
        if (move_req) begin
          m_face = int'(move_dir);
          m_dir  = int'(move_dir);
          if (on_screen(m_x + 16 * dx[move_dir], m_y + 16 * dy[move_dir])) begin
            phase = ASK; waited = 0;
          end
        end
      end else if (phase == ASK) begin
        if (check_done) begin
          if (enemy_collision) begin
            m_hit = 1;
            m_dir = opp[m_face];
            remaining = on_screen(m_x + 16 * dx[m_dir], m_y + 16 * dy[m_dir]) ? 16 : 0;
            phase = SLIDE;
          end else if (map_collision) begin
            phase = REST;
          end else begin
            remaining = 16; phase = SLIDE;
          end
        end else begin
          waited++;
          if (waited == 15) phase = REST;
        end
      end else begin
        if (remaining == 0) phase = REST;
        else if (frame_tick) begin
          m_x += dx[m_dir];
          m_y += dy[m_dir];
          remaining--;
          if (remaining == 0) phase = REST;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      chk("x_char", int'(x_char), m_x);
      chk("y_char", int'(y_char), m_y);
      chk("facing_char", int'(facing_char), m_face);
      chk("direction_char", int'(direction_char), m_dir);
      chk("check_req", int'(check_req), (phase == ASK) ? 1 : 0);
      chk("moving", int'(moving), (phase == SLIDE) ? 1 : 0);
      chk("hit", int'(hit), m_hit);
    end
  end

  // Apply one cycle of inputs, returning at the following falling edge.
  task automatic step(input logic mr, input logic [1:0] md, input logic cd,
                      input logic mc, input logic ec, input logic ft);
    move_req = mr; move_dir = md; check_done = cd;
    map_collision = mc; enemy_collision = ec; frame_tick = ft;
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Free walk: request, grant with a tick in the entry cycle (ignored), 16 ticks.
  task automatic free_move(input logic [1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (16) step(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    started = 1'b1;
    reset = 1'b0;
    chk("rst x", int'(x_char), 160);
    chk("rst y", int'(y_char), 112);
    chk("rst facing", int'(facing_char), 1);
    chk("rst dir", int'(direction_char), 1);
    chk("rst check_req", int'(check_req), 0);
    chk("rst moving", int'(moving), 0);
    chk("rst hit", int'(hit), 0);

    // Free move RIGHT.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("req latency", int'(check_req), 1);
    step(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("check_req drop", int'(check_req), 0);
    chk("entry tick ignored", int'(x_char), 160);
    repeat (15) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("one short", int'(x_char), 175);
    chk("still moving", int'(moving), 1);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("right x", int'(x_char), 176);
    chk("right y", int'(y_char), 112);
    chk("moving falls", int'(moving), 0);
    idle();

    // Walk to the left edge, then a LEFT request must be refused.
    for (int i = 0; i < 11; i++) free_move(2'b10);
    chk("left edge x", int'(x_char), 0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("edge no check", int'(check_req), 0);
    chk("edge facing", int'(facing_char), 2);
    idle();
    chk("edge x", int'(x_char), 0);
    chk("edge y", int'(y_char), 112);

    // UP blocked by a wall.
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wall hit", int'(hit), 0);
    chk("wall y", int'(y_char), 112);
    chk("wall moving", int'(moving), 0);
    idle();

    // DOWN into an enemy (wall flag also set: enemy wins) -> knockback UP.
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("enemy hit", int'(hit), 1);
    chk("knock dir", int'(direction_char), 0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hit one cycle", int'(hit), 0);
    repeat (15) step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("knock y", int'(y_char), 96);
    chk("knock facing", int'(facing_char), 1);
    chk("knock done", int'(moving), 0);
    idle();

    // Timeout: no check_done for 15 cycles.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (14) idle();
    chk("timeout waiting", int'(check_req), 1);
    idle();
    chk("timeout drop", int'(check_req), 0);
    chk("timeout x", int'(x_char), 0);
    // New request; check_done lands in the timeout cycle and wins.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("re-accept", int'(check_req), 1);
    repeat (14) idle();
    step(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("late done wins", int'(moving), 1);
    repeat (16) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("late done x", int'(x_char), 16);
    idle();

    // Knockback off the left edge: hit, but no movement.
    free_move(2'b10);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("edge knock hit", int'(hit), 1);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("edge knock stop", int'(moving), 0);
    chk("edge knock x", int'(x_char), 0);
    chk("edge knock facing", int'(facing_char), 3);

    // Reset in the middle of a move.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("partial x", int'(x_char), 7);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("mid rst x", int'(x_char), 160);
    chk("mid rst y", int'(y_char), 112);
    chk("mid rst moving", int'(moving), 0);
    idle();
    chk("after rst x", int'(x_char), 160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
